// File: rtl/riscv_mem_arbiter.sv
// Round-robin arbiter that shares one main-memory block port between the I-cache
// refill port and the D-cache refill/writeback port, one whole transaction at a time.
module riscv_mem_arbiter #(
  parameter int DATA_WIDTH = 128,
  parameter int S_ADDR     = 10
) (
  input  logic                  i_riscv_arb_clk,
  input  logic                  i_riscv_arb_rst,
  input  logic                  i_riscv_arb_imem_rden,
  input  logic [S_ADDR-1:0]     i_riscv_arb_imem_addr,
  output logic                  o_riscv_arb_imem_ready,
  output logic [DATA_WIDTH-1:0] o_riscv_arb_imem_data_out,
  input  logic                  i_riscv_arb_dmem_rden,
  input  logic                  i_riscv_arb_dmem_wren,
  input  logic [S_ADDR-1:0]     i_riscv_arb_dmem_addr,
  input  logic [DATA_WIDTH-1:0] i_riscv_arb_dmem_data_in,
  output logic                  o_riscv_arb_dmem_ready,
  output logic [DATA_WIDTH-1:0] o_riscv_arb_dmem_data_out,
  output logic                  o_riscv_arb_mem_rden,
  output logic                  o_riscv_arb_mem_wren,
  output logic [S_ADDR-1:0]     o_riscv_arb_mem_addr,
  output logic [DATA_WIDTH-1:0] o_riscv_arb_mem_data_in,
  input  logic                  i_riscv_arb_mem_ready,
  input  logic [DATA_WIDTH-1:0] i_riscv_arb_mem_data_out
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RECOVER} state_e;
  typedef enum logic {SIDE_I = 1'b0, SIDE_D = 1'b1} side_e;

  state_e                state_q, state_d;
  side_e                 rr_ptr_q, rr_ptr_d;
  logic                  mem_rden_q, mem_rden_d;
  logic                  mem_wren_q, mem_wren_d;
  logic [S_ADDR-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                  imem_ready, dmem_ready;
  logic                  d_req, i_req;

  assign d_req = i_riscv_arb_dmem_rden | i_riscv_arb_dmem_wren;
  assign i_req = i_riscv_arb_imem_rden;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_riscv_arb_clk) begin
    if (i_riscv_arb_rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= SIDE_D;
      mem_rden_q <= 1'b0;
      mem_wren_q <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      mem_rden_q <= mem_rden_d;
      mem_wren_q <= mem_wren_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    mem_rden_d = mem_rden_q;
    mem_wren_d = mem_wren_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (d_req && (!i_req || rr_ptr_q == SIDE_D)) begin
          // A write wins over a simultaneous read from the D-cache.
          state_d    = GNT_D;
          mem_wren_d = i_riscv_arb_dmem_wren;
          mem_rden_d = i_riscv_arb_dmem_rden & ~i_riscv_arb_dmem_wren;
          mem_addr_d = i_riscv_arb_dmem_addr;
          mem_data_d = i_riscv_arb_dmem_data_in;
        end else if (i_req) begin
          state_d    = GNT_I;
          mem_rden_d = 1'b1;
          mem_wren_d = 1'b0;
          mem_addr_d = i_riscv_arb_imem_addr;
          mem_data_d = '0;
        end
      end
      GNT_I, GNT_D: begin
        if (i_riscv_arb_mem_ready && !i_riscv_arb_rst) begin
          imem_ready = (state_q == GNT_I);
          dmem_ready = (state_q == GNT_D);
          rr_ptr_d   = (state_q == GNT_I) ? SIDE_D : SIDE_I;
          state_d    = RECOVER;
          mem_rden_d = 1'b0;
          mem_wren_d = 1'b0;
          mem_addr_d = '0;
          mem_data_d = '0;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign o_riscv_arb_imem_ready    = imem_ready;
  assign o_riscv_arb_dmem_ready    = dmem_ready;
  assign o_riscv_arb_imem_data_out = i_riscv_arb_mem_data_out;
  assign o_riscv_arb_dmem_data_out = i_riscv_arb_mem_data_out;
  assign o_riscv_arb_mem_rden      = mem_rden_q;
  assign o_riscv_arb_mem_wren      = mem_wren_q;
  assign o_riscv_arb_mem_addr      = mem_addr_q;
  assign o_riscv_arb_mem_data_in   = mem_data_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: a table of lone transactions plus
// hand-written contention, dropped-request and mid-transaction reset sequences.
module tb_riscv_mem_arbiter;

  localparam int DW = 128;
  localparam int AW = 10;

  typedef struct {
    logic          is_d;
    logic          rden;
    logic          wren;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            lat;
    logic [DW-1:0] rdata;
    logic          exp_rden;
    logic          exp_wren;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_rden;
  logic [AW-1:0] imem_addr;
  logic          imem_ready;
  logic [DW-1:0] imem_dout;
  logic          dmem_rden, dmem_wren;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_din;
  logic          dmem_ready;
  logic [DW-1:0] dmem_dout;
  logic          mem_rden, mem_wren;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_ready;
  logic [DW-1:0] mem_dout;

  int checks   = 0;
  int failures = 0;
  int i_pulses = 0;
  int d_pulses = 0;

  riscv_mem_arbiter #(.DATA_WIDTH(DW), .S_ADDR(AW)) dut (
    .i_riscv_arb_clk          (clk),
    .i_riscv_arb_rst          (rst),
    .i_riscv_arb_imem_rden    (imem_rden),
    .i_riscv_arb_imem_addr    (imem_addr),
    .o_riscv_arb_imem_ready   (imem_ready),
    .o_riscv_arb_imem_data_out(imem_dout),
    .i_riscv_arb_dmem_rden    (dmem_rden),
    .i_riscv_arb_dmem_wren    (dmem_wren),
    .i_riscv_arb_dmem_addr    (dmem_addr),
    .i_riscv_arb_dmem_data_in (dmem_din),
    .o_riscv_arb_dmem_ready   (dmem_ready),
    .o_riscv_arb_dmem_data_out(dmem_dout),
    .o_riscv_arb_mem_rden     (mem_rden),
    .o_riscv_arb_mem_wren     (mem_wren),
    .o_riscv_arb_mem_addr     (mem_addr),
    .o_riscv_arb_mem_data_in  (mem_din),
    .i_riscv_arb_mem_ready    (mem_ready),
    .i_riscv_arb_mem_data_out (mem_dout)
  );

  always #5 clk = ~clk;

  // Ready pulses are counted mid-cycle so "exactly one pulse" can be checked.
  always @(negedge clk) begin
    if (imem_ready === 1'b1) i_pulses++;
    if (dmem_ready === 1'b1) d_pulses++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int ip0, dp0;
    ip0 = i_pulses;
    dp0 = d_pulses;
    if (v.is_d) begin
      dmem_rden = v.rden;
      dmem_wren = v.wren;
      dmem_addr = v.addr;
      dmem_din  = v.wdata;
      imem_addr = ~v.addr;
    end else begin
      imem_rden = 1'b1;
      imem_addr = v.addr;
      dmem_addr = ~v.addr;
    end
    #1;
    check($sformatf("v%0d_not_before_edge", idx), {127'd0, mem_rden | mem_wren}, 128'd0);
    tick();
    check($sformatf("v%0d_mem_rden", idx), {127'd0, mem_rden}, {127'd0, v.exp_rden});
    check($sformatf("v%0d_mem_wren", idx), {127'd0, mem_wren}, {127'd0, v.exp_wren});
    check($sformatf("v%0d_mem_addr", idx), {118'd0, mem_addr}, {118'd0, v.addr});
    if (v.exp_wren) check($sformatf("v%0d_mem_wdata", idx), mem_din, v.wdata);
    for (int c = 1; c < v.lat; c++) begin
      tick();
      check($sformatf("v%0d_hold_c%0d", idx, c), {126'd0, mem_rden, mem_wren},
            {126'd0, v.exp_rden, v.exp_wren});
    end
    mem_ready = 1'b1;
    mem_dout  = v.rdata;
    #1;
    check($sformatf("v%0d_imem_ready", idx), {127'd0, imem_ready}, {127'd0, ~v.is_d});
    check($sformatf("v%0d_dmem_ready", idx), {127'd0, dmem_ready}, {127'd0, v.is_d});
    check($sformatf("v%0d_imem_data", idx), imem_dout, v.rdata);
    check($sformatf("v%0d_dmem_data", idx), dmem_dout, v.rdata);
    tick();
    mem_ready = 1'b0;
    imem_rden = 1'b0;
    dmem_rden = 1'b0;
    dmem_wren = 1'b0;
    check($sformatf("v%0d_recover_idle", idx), {126'd0, mem_rden, mem_wren}, 128'd0);
    check($sformatf("v%0d_i_pulses", idx), i_pulses - ip0, v.is_d ? 0 : 1);
    check($sformatf("v%0d_d_pulses", idx), d_pulses - dp0, v.is_d ? 1 : 0);
    tick();
  endtask

  vec_t vecs[5];

  initial begin
    int ip0;
    vecs[0] = '{1'b0, 1'b1, 1'b0, 10'h2A0, 128'd0, 4,
                128'h0123456789ABCDEF0123456789ABCDEF, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 10'h015, {4{32'hDEADBEEF}}, 2,
                128'h0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 10'h3FF, 128'd0, 1,
                {16{8'hA5}}, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 10'h100, {8{16'h5555}}, 3,
                128'h77, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 10'h000, 128'd0, 3,
                {4{32'hCAFEF00D}}, 1'b1, 1'b0};

    rst = 1'b1; imem_rden = 1'b0; imem_addr = '0;
    dmem_rden = 1'b0; dmem_wren = 1'b0; dmem_addr = '0; dmem_din = '0;
    mem_ready = 1'b0; mem_dout = '0;
    tick();
    tick();
    check("rst_mem_rden",   {127'd0, mem_rden},   128'd0);
    check("rst_mem_wren",   {127'd0, mem_wren},   128'd0);
    check("rst_mem_addr",   {118'd0, mem_addr},   128'd0);
    check("rst_mem_wdata",  mem_din,              128'd0);
    check("rst_imem_ready", {127'd0, imem_ready}, 128'd0);
    check("rst_dmem_ready", {127'd0, dmem_ready}, 128'd0);
    rst = 1'b0;
    tick();

    // Contention straight after reset: D first, then I, then D again.
    imem_rden = 1'b1; imem_addr = 10'h111;
    dmem_rden = 1'b1; dmem_addr = 10'h222;
    tick();
    check("cont1_rden", {127'd0, mem_rden}, 128'd1);
    check("cont1_addr_d", {118'd0, mem_addr}, 128'h222);
    mem_ready = 1'b1; mem_dout = 128'h1111; #1;
    check("cont1_dmem_ready", {127'd0, dmem_ready}, 128'd1);
    check("cont1_imem_quiet", {127'd0, imem_ready}, 128'd0);
    tick();
    mem_ready = 1'b0; dmem_rden = 1'b0;
    check("cont_gap1_recover", {127'd0, mem_rden}, 128'd0);
    tick();
    check("cont_gap2_idle", {127'd0, mem_rden}, 128'd0);
    dmem_rden = 1'b1;
    tick();
    check("cont2_addr_i", {118'd0, mem_addr}, 128'h111);
    check("cont2_rden", {127'd0, mem_rden}, 128'd1);
    mem_ready = 1'b1; mem_dout = 128'h2222; #1;
    check("cont2_imem_ready", {127'd0, imem_ready}, 128'd1);
    check("cont2_dmem_quiet", {127'd0, dmem_ready}, 128'd0);
    tick();
    mem_ready = 1'b0;
    check("cont_gap3_recover", {127'd0, mem_rden}, 128'd0);
    tick();
    check("cont_gap4_idle", {127'd0, mem_rden}, 128'd0);
    tick();
    check("cont3_addr_d", {118'd0, mem_addr}, 128'h222);
    mem_ready = 1'b1; mem_dout = 128'h3333; #1;
    check("cont3_dmem_ready", {127'd0, dmem_ready}, 128'd1);
    check("cont3_imem_quiet", {127'd0, imem_ready}, 128'd0);
    tick();
    mem_ready = 1'b0; imem_rden = 1'b0; dmem_rden = 1'b0;
    tick();
    tick();

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // D read whose request drops one cycle into the grant.
    dmem_rden = 1'b1; dmem_addr = 10'h0AB;
    tick();
    check("drop_granted", {127'd0, mem_rden}, 128'd1);
    tick();
    dmem_rden = 1'b0; dmem_addr = 10'h3C3;
    check("drop_hold1", {127'd0, mem_rden}, 128'd1);
    tick();
    check("drop_hold2", {127'd0, mem_rden}, 128'd1);
    check("drop_hold_addr", {118'd0, mem_addr}, 128'h0AB);
    mem_ready = 1'b1; mem_dout = 128'hBEEF; #1;
    check("drop_dmem_ready", {127'd0, dmem_ready}, 128'd1);
    check("drop_dmem_data", dmem_dout, 128'hBEEF);
    tick();
    mem_ready = 1'b0;
    check("drop_recover", {127'd0, mem_rden}, 128'd0);
    tick();

    // Reset during an I grant; a late memory ready must be ignored.
    ip0 = i_pulses;
    imem_rden = 1'b1; imem_addr = 10'h155;
    tick();
    check("rstmid_granted", {127'd0, mem_rden}, 128'd1);
    rst = 1'b1; imem_rden = 1'b0;
    tick();
    rst = 1'b0; mem_ready = 1'b1; mem_dout = 128'hF00D; #1;
    check("rstmid_mem_rden", {127'd0, mem_rden}, 128'd0);
    check("rstmid_imem_ready", {127'd0, imem_ready}, 128'd0);
    check("rstmid_dmem_ready", {127'd0, dmem_ready}, 128'd0);
    tick();
    mem_ready = 1'b0;
    check("rstmid_still_idle", {127'd0, mem_rden}, 128'd0);
    check("rstmid_no_i_pulse", i_pulses - ip0, 128'd0);
    imem_rden = 1'b1; imem_addr = 10'h155;
    dmem_rden = 1'b1; dmem_addr = 10'h2AA;
    tick();
    check("rstmid_d_first", {118'd0, mem_addr}, 128'h2AA);
    mem_ready = 1'b1; #1;
    check("rstmid_d_ready", {127'd0, dmem_ready}, 128'd1);
    tick();
    mem_ready = 1'b0; imem_rden = 1'b0; dmem_rden = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
